// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop rx synchroniser, mid-bit sampling FSM and a small receive FIFO with a 1-cycle pop port.
// Optional even-parity frame format is enabled by defining UART_RECEIVER_PARITY_EN.
module uart_receiver #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       read_req,
  output logic [7:0] read_data,
  output logic       read_data_valid,
  output logic       data_available,
  output logic       framing_error,
  output logic       overflow,
  output logic       parity_error,
  input  logic       error_clear
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CNT_W-1:0]         HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]         BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] OCC_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic                       rx_meta_reg, rx_s_reg;
  state_t                     state_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [2:0]                 bit_idx_reg;
  logic [7:0]                 shift_reg;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   count_reg;
  logic [7:0]                 read_data_reg;
  logic                       read_data_valid_reg;
  logic                       framing_error_reg, overflow_reg;

  logic bit_done, stop_sample, frame_ok, framing_set;
  logic fifo_full, fifo_empty, push_ok, pop_ok, overflow_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign bit_done    = (cnt_reg == BIT_LAST);
  assign stop_sample = (state_reg == S_STOP) && bit_done;
  assign framing_set = stop_sample && !rx_s_reg;
  assign fifo_full   = (count_reg == FULL_CNT);
  assign fifo_empty  = (count_reg == '0);

`ifdef UART_RECEIVER_PARITY_EN
  logic parity_bad_reg, parity_error_reg, parity_set;
  // Even parity: data bits XOR parity bit must be zero.
  assign parity_set = (state_reg == S_PARITY) && bit_done && (^{shift_reg, rx_s_reg});
  assign frame_ok   = stop_sample && rx_s_reg && !parity_bad_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bad_reg   <= 1'b0;
      parity_error_reg <= 1'b0;
    end else begin
      if (state_reg == S_PARITY && bit_done) parity_bad_reg <= parity_set;
      parity_error_reg <= (parity_error_reg & ~error_clear) | parity_set;
    end
  end
  assign parity_error = parity_error_reg;
`else
  assign frame_ok     = stop_sample && rx_s_reg;
  assign parity_error = 1'b0;
`endif

  assign push_ok      = frame_ok && !fifo_full;
  assign overflow_set = frame_ok && fifo_full;
  assign pop_ok       = read_req && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (!rx_s_reg) begin
            cnt_reg   <= '0;
            state_reg <= S_START;
          end
        end
        S_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_s_reg ? S_IDLE : S_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
              state_reg <= S_PARITY;
`else
              state_reg <= S_STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`ifdef UART_RECEIVER_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= S_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= rx_s_reg ? S_IDLE : S_BREAK;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        // A held-low line must return high before another start bit is accepted.
        S_BREAK: begin
          if (rx_s_reg) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg          <= '0;
      rd_ptr_reg          <= '0;
      count_reg           <= '0;
      read_data_reg       <= '0;
      read_data_valid_reg <= 1'b0;
      framing_error_reg   <= 1'b0;
      overflow_reg        <= 1'b0;
    end else begin
      read_data_valid_reg <= read_req;
      // An empty pop still answers so the bus never stalls.
      if (read_req) read_data_reg <= fifo_empty ? 8'h00 : mem[rd_ptr_reg];
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + OCC_ONE;
        2'b01:   count_reg <= count_reg - OCC_ONE;
        default: count_reg <= count_reg;
      endcase
      framing_error_reg <= (framing_error_reg & ~error_clear) | framing_set;
      overflow_reg      <= (overflow_reg & ~error_clear) | overflow_set;
    end
  end

  assign read_data       = read_data_reg;
  assign read_data_valid = read_data_valid_reg;
  assign data_available  = !fifo_empty;
  assign framing_error   = framing_error_reg;
  assign overflow        = overflow_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver at 4 clocks per bit and an 8-entry FIFO,
// checked against a queue-based frame/FIFO model.
module tb_uart_receiver;

  localparam int CPB   = 4;
  localparam int DLOG2 = 3;
  localparam int DEPTH = 1 << DLOG2;
`ifdef UART_RECEIVER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Start edge -> 2 sync flops -> idle detect -> half bit -> data(+parity) and stop bits.
  localparam int STOP_EDGE = 3 + CPB / 2 + (NBITS - 1) * CPB;

  logic       clk, reset, rx, read_req, error_clear;
  logic [7:0] read_data;
  logic       read_data_valid, data_available, framing_error, overflow, parity_error;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .read_req(read_req),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .data_available(data_available), .framing_error(framing_error),
    .overflow(overflow), .parity_error(parity_error), .error_clear(error_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic exp_fe, exp_ovf, exp_pe;
  logic pv, ab, aa;
  logic [7:0] pd, exp_pop, d;
  int pop_at;
  logic bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                            input int pop_k, input int reset_k, input int tail_low,
                            output logic pop_valid, output logic [7:0] pop_data,
                            output logic avail_before, output logic avail_at);
    logic [NBITS-1:0] frame;
`ifdef UART_RECEIVER_PARITY_EN
    frame = {stop_bit, (^data) ^ par_flip, data, 1'b0};
`else
    frame = {stop_bit, data, 1'b0};
    if (par_flip) frame = {stop_bit, data, 1'b0};
`endif
    pop_valid = 1'b0; pop_data = 8'h00; avail_before = 1'b0; avail_at = 1'b0;
    for (int k = 0; k < NBITS * CPB + tail_low + 4; k++) begin
      if (reset_k >= 0 && k > reset_k) rx = 1'b1;
      else if (k < NBITS * CPB)        rx = frame[k / CPB];
      else if (k < NBITS * CPB + tail_low) rx = 1'b0;
      else                             rx = 1'b1;
      read_req = (k == pop_k);
      reset    = (k == reset_k);
      tick();
      if (k == pop_k) begin
        pop_valid = read_data_valid;
        pop_data  = read_data;
      end
      if (k == STOP_EDGE - 2) avail_before = data_available;
      if (k == STOP_EDGE - 1) avail_at = data_available;
    end
    read_req = 1'b0;
    reset    = 1'b0;
    rx       = 1'b1;
  endtask

  // Model: push and pop both judged on occupancy before the stop-sample cycle.
  task automatic model_frame(input logic [7:0] data, input logic good, input logic popped,
                             output logic [7:0] exp_p);
    logic pre_full;
    pre_full = (q.size() == DEPTH);
    exp_p = 8'h00;
    if (popped && q.size() > 0) exp_p = q.pop_front();
    if (good) begin
      if (pre_full) exp_ovf = 1'b1;
      else q.push_back(data);
    end
  endtask

  task automatic do_pop(input string tag);
    logic [7:0] e;
    e = (q.size() > 0) ? q.pop_front() : 8'h00;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk({tag, "_valid"}, {31'd0, read_data_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, read_data}, {24'd0, e});
    tick();
    chk({tag, "_valid_off"}, {31'd0, read_data_valid}, 32'd0);
    chk({tag, "_hold"}, {24'd0, read_data}, {24'd0, e});
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_avail"}, {31'd0, data_available}, {31'd0, q.size() != 0});
    chk({tag, "_fe"}, {31'd0, framing_error}, {31'd0, exp_fe});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    chk({tag, "_pe"}, {31'd0, parity_error}, {31'd0, exp_pe});
  endtask

  task automatic clear_errors();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    exp_fe = 1'b0; exp_ovf = 1'b0; exp_pe = 1'b0;
  endtask

  initial begin
    rx = 1'b1; reset = 1'b1; read_req = 1'b0; error_clear = 1'b0;
    exp_fe = 1'b0; exp_ovf = 1'b0; exp_pe = 1'b0;
    repeat (3) tick();
    chk("rst_rdata", {24'd0, read_data}, 32'd0);
    chk("rst_valid", {31'd0, read_data_valid}, 32'd0);
    chk_status("rst");
    reset = 1'b0;
    tick();
    chk_status("post_rst");
    do_pop("empty_pop");
    $display("txn reset/empty pop done");

    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 0, pv, pd, ab, aa);
    model_frame(8'hA5, 1'b1, 1'b0, exp_pop);
    chk("a5_avail_before", {31'd0, ab}, 32'd0);
    chk("a5_avail_at", {31'd0, aa}, 32'd1);
    do_pop("a5_pop");
    chk_status("a5");
    $display("txn byte a5 received");

    rx = 1'b0; tick(); rx = 1'b1;
    repeat (12) tick();
    chk_status("glitch");
    $display("txn glitch rejected");

    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 20, pv, pd, ab, aa);
    model_frame(8'h3C, 1'b0, 1'b0, exp_pop);
    exp_fe = 1'b1;
    chk_status("framing");
    send_frame(8'h55, 1'b1, 1'b0, -1, -1, 0, pv, pd, ab, aa);
    model_frame(8'h55, 1'b1, 1'b0, exp_pop);
    do_pop("after_break_pop");
    clear_errors();
    tick();
    chk_status("fe_cleared");
    $display("txn framing error and recovery");

    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, 1'b0, -1, -1, 0, pv, pd, ab, aa);
      model_frame(d, 1'b1, 1'b0, exp_pop);
    end
    chk_status("ovf_full");
    for (int i = 0; i <= DEPTH; i++) do_pop("ovf_drain");
    chk_status("ovf_drained");
    clear_errors();
    $display("txn overflow fill/drain");

    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'b0, -1, -1, 0, pv, pd, ab, aa);
      model_frame(d, 1'b1, 1'b0, exp_pop);
    end
    send_frame(8'h77, 1'b1, 1'b0, STOP_EDGE - 1, -1, 0, pv, pd, ab, aa);
    model_frame(8'h77, 1'b1, 1'b1, exp_pop);
    chk("full_simul_valid", {31'd0, pv}, 32'd1);
    chk("full_simul_data", {24'd0, pd}, {24'd0, exp_pop});
    chk_status("full_simul");
    while (q.size() > 0) do_pop("full_simul_drain");
    clear_errors();
    send_frame(8'h99, 1'b1, 1'b0, STOP_EDGE - 1, -1, 0, pv, pd, ab, aa);
    model_frame(8'h99, 1'b1, 1'b1, exp_pop);
    chk("empty_simul_data", {24'd0, pd}, {24'd0, exp_pop});
    chk_status("empty_simul");
    do_pop("empty_simul_pop");
    $display("txn simultaneous push/pop");

    send_frame(8'h81, 1'b1, 1'b0, -1, 3 + CPB / 2 + 3 * CPB, 0, pv, pd, ab, aa);
    q.delete();
    exp_fe = 1'b0; exp_ovf = 1'b0; exp_pe = 1'b0;
    repeat (2 * CPB) tick();
    chk_status("mid_reset");
    send_frame(8'h42, 1'b1, 1'b0, -1, -1, 0, pv, pd, ab, aa);
    model_frame(8'h42, 1'b1, 1'b0, exp_pop);
    do_pop("post_reset_pop");
    $display("txn mid-frame reset");

`ifdef UART_RECEIVER_PARITY_EN
    send_frame(8'h42, 1'b1, 1'b1, -1, -1, 0, pv, pd, ab, aa);
    exp_pe = 1'b1;
    chk_status("parity_bad");
    clear_errors();
    $display("txn parity error");
`endif

    for (int i = 0; i < 30; i++) begin
      d      = 8'($urandom);
      bad    = ($urandom_range(0, 7) == 0);
      pop_at = ($urandom_range(0, 3) == 0) ? STOP_EDGE - 1 : -1;
      send_frame(d, !bad, 1'b0, pop_at, -1, bad ? CPB : 0, pv, pd, ab, aa);
      model_frame(d, !bad, pop_at >= 0, exp_pop);
      if (bad) exp_fe = 1'b1;
      if (pop_at >= 0) chk("rand_simul_data", {24'd0, pd}, {24'd0, exp_pop});
      for (int j = 0; j < int'($urandom_range(0, 1)); j++) do_pop("rand_pop");
      chk_status("rand");
      $display("txn rand %0d byte=%02h bad_stop=%0b simul_pop=%0b depth=%0d", i, d, bad, pop_at >= 0, q.size());
    end
    while (q.size() > 0) do_pop("final_drain");
    chk_status("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
